// File: rtl/calc_pkg.sv
// calc_pkg: key codes, operator/state enums and saturation helper for the keypad calculator.
package calc_pkg;
  localparam logic [3:0] KEY_PLUS = 4'hA, KEY_MINUS = 4'hB, KEY_MUL = 4'hC, KEY_DIV = 4'hD, KEY_CLR = 4'hE, KEY_EQ = 4'hF;
  typedef enum logic [1:0] {OP_PLUS, OP_MINUS, OP_MUL, OP_DIV} op_t;
  typedef enum logic [2:0] {S_IDLE, S_DIGIT, S_CALC, S_DIV, S_SHOW_ARG, S_SHOW_RES, S_CLEAR} state_t;
  function automatic op_t key2op(logic [3:0] k);
    return op_t'(k[1:0] - 2'd2);
  endfunction
  function automatic longint sat(longint v, int w);
    longint mx;
    mx = (longint'(1) <<< (w - 1)) - 1;
    return v > mx ? mx : v < -mx - 1 ? -mx - 1 : v;
  endfunction
endpackage

// File: rtl/calculator_param_if.sv
// calculator_param_if: key event input and display/status outputs of the calculator.
interface calculator_param_if #(parameter int WIDTH = 14);
  logic key_valid;
  logic [3:0] key_code;
  logic key_ready;
  logic [WIDTH-1:0] display;
  logic display_neg, overflow, div_zero, busy;
  modport master (output key_valid, key_code, input key_ready, display, display_neg, overflow, div_zero, busy);
  modport slave (input key_valid, key_code, output key_ready, display, display_neg, overflow, div_zero, busy);
endinterface

// File: rtl/calc_divider.sv
// calc_divider: restoring unsigned divider, one quotient bit per cycle, done WIDTH cycles after start.
module calc_divider #(parameter int WIDTH = 14) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             done,
  output logic [WIDTH-1:0] quotient
);
  localparam int CW = $clog2(WIDTH + 1);
  logic [WIDTH-1:0] rem_q, rem_d, quo_q, quo_d, div_q, div_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic run_q, run_d;
  logic [WIDTH:0] shl, trial;
  always_comb begin
    shl = {rem_q, quo_q[WIDTH-1]};
    trial = shl - {1'b0, div_q};
    rem_d = rem_q;
    quo_d = quo_q;
    div_d = div_q;
    cnt_d = cnt_q;
    run_d = run_q;
    if (start) begin
      rem_d = '0;
      quo_d = dividend;
      div_d = divisor;
      cnt_d = CW'(WIDTH);
      run_d = 1'b1;
    end else if (run_q) begin
      rem_d = trial[WIDTH] ? shl[WIDTH-1:0] : trial[WIDTH-1:0];
      quo_d = {quo_q[WIDTH-2:0], ~trial[WIDTH]};
      cnt_d = cnt_q - 1'b1;
      run_d = cnt_q != CW'(1);
    end
  end
  // The final quotient is forwarded combinationally in the last step so busy lasts exactly WIDTH cycles.
  assign done = run_q && cnt_q == CW'(1);
  assign quotient = quo_d;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      rem_q <= '0;
      quo_q <= '0;
      div_q <= '0;
      cnt_q <= '0;
      run_q <= 1'b0;
    end else begin
      rem_q <= rem_d;
      quo_q <= quo_d;
      div_q <= div_d;
      cnt_q <= cnt_d;
      run_q <= run_d;
    end
endmodule

// File: rtl/calculator_param.sv
// calculator_param: keypad calculator FSM with signed saturating + - * /, sign/magnitude display.
module calculator_param
  import calc_pkg::*;
#(
  parameter int WIDTH = 14,
  parameter int MAX_DIGITS = 4,
  parameter int ENABLE_DIV = 1
) (
  input logic clk,
  input logic rst,
  calculator_param_if.slave bus
);
  localparam int DW = $clog2(MAX_DIGITS + 1);
  localparam longint MAXV = (longint'(1) <<< (WIDTH - 1)) - 1;
  state_t state_q, state_d;
  op_t pend_q, pend_d;
  logic signed [WIDTH-1:0] arg_q, arg_d, res_q, res_d;
  logic [WIDTH-1:0] disp_q, disp_d, mag_r, quo;
  logic [3:0] key_q, key_d;
  logic [DW-1:0] dig_q, dig_d;
  logic ent_q, ent_d, fresh_q, fresh_d, qneg_q, qneg_d, ovf_q, ovf_d, dz_q, dz_d, dneg_q, dneg_d;
  logic div_start, div_done;
  longint wide, satv, next_arg;
  always_comb begin
    state_d = state_q;
    pend_d = pend_q;
    arg_d = arg_q;
    res_d = res_q;
    disp_d = disp_q;
    key_d = key_q;
    dig_d = dig_q;
    ent_d = ent_q;
    fresh_d = fresh_q;
    qneg_d = qneg_q;
    ovf_d = ovf_q;
    dz_d = dz_q;
    dneg_d = dneg_q;
    div_start = 1'b0;
    wide = pend_q == OP_PLUS ? longint'(res_q) + longint'(arg_q) :
           pend_q == OP_MINUS ? longint'(res_q) - longint'(arg_q) : longint'(res_q) * longint'(arg_q);
    if (state_q == S_DIV) wide = qneg_q ? -longint'(quo) : longint'(quo);
    satv = sat(wide, WIDTH);
    next_arg = longint'(arg_q) * 10 + longint'(key_q);
    mag_r = res_q[WIDTH-1] ? -res_q : res_q;
    case (state_q)
      S_IDLE:
        if (bus.key_valid) begin
          key_d = bus.key_code;
          if (bus.key_code <= 4'd9) state_d = S_DIGIT;
          else if (bus.key_code == KEY_CLR) state_d = S_CLEAR;
          else if (bus.key_code == KEY_DIV && ENABLE_DIV == 0) state_d = S_IDLE;
          else if (bus.key_code == KEY_EQ || ent_q) state_d = S_CALC;
          else begin
            pend_d = key2op(bus.key_code);
            fresh_d = 1'b0;
          end
        end
      S_DIGIT: begin
        if (fresh_q) begin
          res_d = '0;
          fresh_d = 1'b0;
        end
        if (dig_q < DW'(MAX_DIGITS) && next_arg <= MAXV) begin
          arg_d = WIDTH'(next_arg);
          dig_d = dig_q + 1'b1;
          ent_d = 1'b1;
        end
        state_d = S_SHOW_ARG;
      end
      S_CALC: begin
        pend_d = key_q == KEY_EQ ? OP_PLUS : key2op(key_q);
        arg_d = '0;
        dig_d = '0;
        ent_d = 1'b0;
        fresh_d = key_q == KEY_EQ;
        state_d = S_SHOW_RES;
        if (pend_q != OP_DIV) begin
          res_d = WIDTH'(satv);
          ovf_d = ovf_q | (satv != wide);
        end else if (arg_q == '0) dz_d = 1'b1;
        else begin
          div_start = 1'b1;
          qneg_d = res_q[WIDTH-1] ^ arg_q[WIDTH-1];
          state_d = S_DIV;
        end
      end
      S_DIV:
        if (div_done) begin
          res_d = WIDTH'(satv);
          ovf_d = ovf_q | (satv != wide);
          state_d = S_SHOW_RES;
        end
      S_CLEAR: begin
        pend_d = OP_PLUS;
        {arg_d, res_d, disp_d, key_d, dig_d} = '0;
        {ent_d, fresh_d, qneg_d, ovf_d, dz_d, dneg_d} = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (state_d == S_SHOW_ARG) begin
      disp_d = arg_d;
      dneg_d = 1'b0;
    end else if (state_d == S_SHOW_RES) begin
      disp_d = res_d[WIDTH-1] ? -res_d : res_d;
      dneg_d = res_d[WIDTH-1];
    end
  end
  generate
    if (ENABLE_DIV != 0) begin : g_div
      calc_divider #(.WIDTH(WIDTH)) u_div (
        .clk(clk), .rst(rst), .start(div_start), .dividend(mag_r), .divisor(arg_q),
        .done(div_done), .quotient(quo)
      );
    end else begin : g_nodiv
      logic unused_div;
      assign unused_div = ^{div_start, mag_r};
      assign div_done = 1'b0;
      assign quo = '0;
    end
  endgenerate
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= S_IDLE;
      pend_q <= OP_PLUS;
      {arg_q, res_q, disp_q, key_q, dig_q} <= '0;
      {ent_q, fresh_q, qneg_q, ovf_q, dz_q, dneg_q} <= '0;
    end else begin
      state_q <= state_d;
      pend_q <= pend_d;
      arg_q <= arg_d;
      res_q <= res_d;
      disp_q <= disp_d;
      key_q <= key_d;
      dig_q <= dig_d;
      ent_q <= ent_d;
      fresh_q <= fresh_d;
      qneg_q <= qneg_d;
      ovf_q <= ovf_d;
      dz_q <= dz_d;
      dneg_q <= dneg_d;
    end
  assign bus.key_ready = state_q == S_IDLE;
  assign bus.busy = state_q == S_DIV;
  assign bus.display = disp_q;
  assign bus.display_neg = dneg_q;
  assign bus.overflow = ovf_q;
  assign bus.div_zero = dz_q;
endmodule
